// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit path: serializer state
//   encoding, data width and the number of bit slots in one 8N1 frame.
//   No ports; imported by uart_byte_fifo and uart_tx_fifo.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    // start + 8 data + stop
    localparam int FRAME_BITS  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo
//   Synchronous FIFO with a combinational head read (dout always shows
//   the oldest entry). Full/empty come straight from the registered
//   occupancy count, so neither flag depends on this cycle's push/pop.
// Ports:
//   CLK    system clock, rising edge
//   RST    asynchronous active-high reset, empties the FIFO
//   push   write din this cycle (ignored when full)
//   din    data to write
//   pop    discard the head entry this cycle (ignored when empty)
//   dout   head entry
//   full   DEPTH entries held
//   empty  no entries held
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   8N1 UART transmitter fed by a valid/ready byte stream. A small FIFO
//   absorbs bursts; the serializer drains it and sends frames
//   back-to-back when more bytes are waiting.
// Ports:
//   CLK       system clock, rising edge
//   RST       asynchronous active-high reset (abandons any frame)
//   wr_valid  upstream presents a byte
//   wr_data   byte to send, sampled only on wr_valid && wr_ready
//   wr_ready  FIFO not full
//   tx        registered serial line, idle high
//   tx_busy   frame in progress or bytes still queued
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit period
// DATA  | 8 data bits, LSB first, one bit period each
// STOP  | stop bit (high); chains into START if more bytes are queued
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   wr_valid,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   wr_ready,
    output logic                   tx,
    output logic                   tx_busy
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    tx_state_t              state;
    logic [BAUD_W-1:0]      baud_cnt;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] sh;
    logic                   baud_end;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_dout;

    assign wr_ready  = !fifo_full;
    assign fifo_push = wr_valid && wr_ready;
    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign tx_busy   = (state != IDLE) || !fifo_empty;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .din   (wr_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The head byte is taken either from idle or at the very end of a
    // stop bit, which is what makes consecutive frames gap-free.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            IDLE:    fifo_pop = !fifo_empty;
            STOP:    fifo_pop = baud_end && !fifo_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (fifo_pop) begin
                        sh    <= fifo_dout;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= sh[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        sh       <= sh >> 1;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // sh[1] is the bit that lands in sh[0] after this shift
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= sh[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (fifo_pop) begin
                            sh    <= fifo_dout;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
//   Accepted bytes go into a scoreboard queue; a cycle-by-cycle serial
//   decoder pops the expected byte at each start bit and checks the
//   full frame waveform and the decoded value.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_LEN = FRAME_BITS * CPB;

    logic       CLK;
    logic       RST;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       tx;
    logic       tx_busy;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int         cyc = 0;
    logic [7:0] sb_q[$];
    int         gap_q[$];
    int         hs_cnt = 0;
    int         hs_cyc = 0;
    int         frames_done = 0;
    int         start_cyc = 0;
    int         max_occ = 0;
    bit         dec_active = 0;
    int         dec_cyc = 0;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Handshake monitor: inputs and wr_ready are stable from posedge+1
    // to the next posedge, so a negedge sample predicts the transfer.
    initial forever begin
        @(negedge CLK);
        if (!RST && wr_valid && wr_ready) begin
            sb_q.push_back(wr_data);
            hs_cnt++;
            hs_cyc = cyc;
        end
    end

    // Serial decoder / scoreboard consumer.
    initial begin
        int         idle_cnt;
        int         wave_err;
        int         field;
        bit         have_exp;
        logic [7:0] exp_byte;
        logic [7:0] rx_byte;
        logic       exp_bit;
        idle_cnt = 0;
        wave_err = 0;
        have_exp = 0;
        exp_byte = '0;
        rx_byte  = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                dec_active = 0;
                idle_cnt   = 0;
            end else begin
                if (!dec_active && tx === 1'b0) begin
                    dec_active = 1;
                    dec_cyc    = 0;
                    wave_err   = 0;
                    rx_byte    = '0;
                    start_cyc  = cyc;
                    gap_q.push_back(idle_cnt);
                    idle_cnt   = 0;
                    if (sb_q.size() == 0) begin
                        check("spurious_frame", 1, 0);
                        have_exp = 0;
                        exp_byte = '0;
                    end else begin
                        exp_byte = sb_q.pop_front();
                        have_exp = 1;
                    end
                    if (sb_q.size() > max_occ) max_occ = sb_q.size();
                end else if (!dec_active) begin
                    idle_cnt++;
                end else begin
                    dec_cyc++;
                end
                if (dec_active) begin
                    field = dec_cyc / CPB;
                    if (field == 0)      exp_bit = 1'b0;
                    else if (field == 9) exp_bit = 1'b1;
                    else                 exp_bit = exp_byte[field-1];
                    if (tx !== exp_bit) wave_err++;
                    if ((dec_cyc % CPB) == CPB/2 && field >= 1 && field <= 8)
                        rx_byte[field-1] = tx;
                    if (dec_cyc == FRAME_LEN - 1) begin
                        if (have_exp) check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_byte});
                        check("frame_wave", wave_err, 0);
                        frames_done++;
                        dec_active = 0;
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input bit keep);
        int waited;
        bit done;
        waited   = 0;
        done     = 0;
        wr_valid = 1'b1;
        wr_data  = b;
        while (!done && waited < 2000) begin
            @(negedge CLK);
            if (wr_ready) done = 1;
            waited++;
        end
        if (!done) check("hs_timeout", 0, 1);
        @(posedge CLK);
        #1;
        if (!keep || !done) begin
            wr_valid = 1'b0;
            wr_data  = 8'($urandom);
        end
    endtask

    task automatic drain(input int limit);
        int w;
        w = 0;
        while ((sb_q.size() != 0 || dec_active || tx_busy) && w < limit) begin
            @(negedge CLK);
            w++;
        end
        if (w >= limit) check("drain_timeout", 0, 1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int f0;
        int h0;
        int low_cnt;
        int bad_cnt;
        int gap_sum;
        int w;
        int rise_cyc;
        bit first;
        bit done;

        RST      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_tx", tx, 1);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_tx_busy", tx_busy, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Single byte 0x41: latency, waveform, tx_busy span.
        f0 = frames_done;
        send_byte(8'h41, 0);
        low_cnt = 0;
        for (int k = 1; k <= FRAME_LEN + 1; k++) begin
            @(negedge CLK);
            if (k == 1) check("tx_high_before_pop", tx, 1);
            if (tx_busy !== 1'b1) low_cnt++;
        end
        check("busy_during_frame", low_cnt, 0);
        @(negedge CLK);
        check("busy_after_frame", tx_busy, 0);
        check("tx_idle_after_frame", tx, 1);
        check("first_latency", start_cyc - hs_cyc, 2);
        check("single_frames", frames_done - f0, 1);
        @(posedge CLK);
        #1;

        // Burst of 6 with wr_valid held, then full-with-pop behaviour.
        f0 = frames_done;
        h0 = hs_cnt;
        gap_q.delete();
        wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(i);
            first   = 1;
            done    = 0;
            w       = 0;
            while (!done && w < 2000) begin
                @(negedge CLK);
                if (i == 5 && first) check("burst_full_ready", wr_ready, 0);
                first = 0;
                if (wr_ready) done = 1;
                w++;
            end
            if (!done) check("hs_timeout", 0, 1);
            @(posedge CLK);
            #1;
        end
        wr_valid = 1'b0;
        // FIFO is full again; the next pop happens with it full.
        rise_cyc = -1;
        w = 0;
        while (rise_cyc < 0 && w < 200) begin
            @(negedge CLK);
            if (wr_ready) rise_cyc = cyc;
            w++;
        end
        check("ready_rise_seen", (rise_cyc >= 0), 1);
        @(negedge CLK);
        check("ready_rise_at_pop", rise_cyc, start_cyc);
        check("ready_after_pop", wr_ready, 1);
        @(posedge CLK);
        #1;
        drain(2000);
        check("burst_handshakes", hs_cnt - h0, 6);
        check("burst_frames", frames_done - f0, 6);
        check("burst_gap_count", gap_q.size(), 6);
        gap_sum = 0;
        for (int i = 1; i < gap_q.size(); i++) gap_sum += gap_q[i];
        check("burst_contiguous", gap_sum, 0);

        // wr_valid low with wr_data toggling.
        f0 = frames_done;
        bad_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            wr_data = 8'($urandom);
            @(negedge CLK);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad_cnt++;
            @(posedge CLK);
            #1;
        end
        check("quiet_line", bad_cnt, 0);
        check("quiet_frames", frames_done - f0, 0);

        // Reset during DATA bit 3 of 0xA5.
        f0 = frames_done;
        send_byte(8'hA5, 0);
        w = 0;
        while (!(dec_active && dec_cyc == 4*CPB + 1) && w < 200) begin
            @(negedge CLK);
            w++;
        end
        check("reached_bit3", (w < 200), 1);
        check("tx_is_bit3", tx, 0);
        #1;
        RST = 1'b1;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_wr_ready", wr_ready, 1);
        check("mid_rst_busy", tx_busy, 0);
        sb_q.delete();
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_busy", tx_busy, 0);
        @(posedge CLK);
        #1;
        send_byte(8'h3C, 0);
        drain(500);
        check("post_rst_frames", frames_done - f0, 1);

        // Pointer wrap: 20 bytes with random gaps.
        f0 = frames_done;
        h0 = hs_cnt;
        max_occ = 0;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            #1;
            send_byte(8'(i), 0);
        end
        drain(20 * FRAME_LEN + 500);
        check("wrap_handshakes", hs_cnt - h0, 20);
        check("wrap_frames", frames_done - f0, 20);
        check("wrap_max_occ", (max_occ <= DEPTH), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
